// File: rtl/ifu_fetch_pkg.sv
// ifu_fetch_pkg: shared types and constants for the instruction fetch unit.
//   ifu_state_t   - fetch FSM state encoding
//   RESP_OKAY     - AXI-lite read response code for success
//   IFU_RESET_PC  - default PC after reset (first fetch address)
//   IFU_NOP_INS   - default word substituted on a fetch error (addi x0,x0,0)
//   pc_align()    - clear the byte-offset bits of a PC
//   pc_misaligned() - true when a PC is not word aligned
package ifu_fetch_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_RESP = 2'd1,
        S_HOLD = 2'd2,
        S_WAIT = 2'd3
    } ifu_state_t;

    localparam logic [1:0]  RESP_OKAY    = 2'b00;
    localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;
    localparam logic [31:0] IFU_NOP_INS  = 32'h0000_0013;

    function automatic logic [31:0] pc_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    function automatic logic pc_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/ifu_fetch.sv
// ifu_fetch: multicycle instruction fetch unit, producer side of the
// fetch->decode handshake. One AXI-lite read (AR + R) per instruction; the
// fetched word is held with ifu_valid until decode takes it, then the unit
// idles until the commit stage hands over the next PC.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   pc, ins, ifu_valid       instruction + its address towards decode
//   idu_ready                decode accepts (ifu_valid & idu_ready)
//   pc_upd_valid, next_pc    next PC pulse from commit (only used in S_WAIT)
//   mem_ar*                  read address channel (araddr = pc)
//   mem_r*                   read data channel
//   fetch_err                sticky: bad read response or misaligned next_pc
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = IFU_RESET_PC,
    parameter logic [31:0] NOP_INS  = IFU_NOP_INS
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] pc,
    output logic [31:0] ins,
    output logic        ifu_valid,
    input  logic        idu_ready,
    input  logic        pc_upd_valid,
    input  logic [31:0] next_pc,
    output logic [31:0] mem_araddr,
    output logic        mem_arvalid,
    input  logic        mem_arready,
    input  logic [31:0] mem_rdata,
    input  logic [1:0]  mem_rresp,
    input  logic        mem_rvalid,
    output logic        mem_rready,
    output logic        fetch_err
);

    ifu_state_t state_q, state_d;

    // Handshake events, each qualified by the state that owns it so that
    // stray inputs in other states cannot move the machine.
    logic ar_fire;
    logic r_fire;
    logic id_fire;
    logic pc_fire;

    assign ar_fire = (state_q == S_REQ)  && mem_arready;
    assign r_fire  = (state_q == S_RESP) && mem_rvalid;
    assign id_fire = (state_q == S_HOLD) && idu_ready;
    assign pc_fire = (state_q == S_WAIT) && pc_upd_valid;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next state and Moore handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        mem_arvalid = 1'b0;
        mem_rready  = 1'b0;
        ifu_valid   = 1'b0;

        unique case (state_q)
            S_REQ: begin
                // The reset state is S_REQ, but no request may be presented
                // while rst is still held, so arvalid is masked by rst.
                mem_arvalid = !rst;
                if (ar_fire) state_d = S_RESP;
            end
            S_RESP: begin
                mem_rready = 1'b1;
                if (r_fire) state_d = S_HOLD;
            end
            S_HOLD: begin
                ifu_valid = 1'b1;
                if (id_fire) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (pc_fire) state_d = S_REQ;
            end
            default: state_d = S_REQ;
        endcase
    end

    assign mem_araddr = pc;

    // ------------------------------------------------------------------
    // PC register: only the commit stage moves it, and only in S_WAIT,
    // so araddr is stable across a stalled AR and pc is frozen in S_HOLD.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (pc_fire) begin
            pc <= pc_align(next_pc);
        end
    end

    // ------------------------------------------------------------------
    // Instruction register: captured once per fetch on the R beat. A
    // failed read delivers a NOP so decode still sees a harmless word.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            ins <= '0;
        end else if (r_fire) begin
            ins <= (mem_rresp == RESP_OKAY) ? mem_rdata : NOP_INS;
        end
    end

    // ------------------------------------------------------------------
    // Sticky error flag, cleared only by reset
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_err <= 1'b0;
        end else if ((r_fire && (mem_rresp != RESP_OKAY)) ||
                     (pc_fire && pc_misaligned(next_pc))) begin
            fetch_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed + randomized bench for ifu_fetch. The bench plays the
// memory responder, decode and commit stages; expected pc/ins/fetch_err are
// tracked per instruction from the fetch rules (aligned next PC, OKAY data
// or NOP, sticky error), and handshake outputs are checked every cycle.
module tb_ifu_fetch;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc, ins, mem_araddr;
    logic        ifu_valid, mem_arvalid, mem_rready, fetch_err;
    logic        idu_ready = 1'b0;
    logic        pc_upd_valid = 1'b0;
    logic [31:0] next_pc = '0;
    logic        mem_arready = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [1:0]  mem_rresp = '0;
    logic        mem_rvalid = 1'b0;

    int checks   = 0;
    int failures = 0;

    // reference state, one entry per architectural instruction
    logic [31:0] exp_pc  = RST_PC;
    logic [31:0] exp_ins = '0;
    logic        exp_err = 1'b0;

    ifu_fetch dut (
        .clk          (clk),
        .rst          (rst),
        .pc           (pc),
        .ins          (ins),
        .ifu_valid    (ifu_valid),
        .idu_ready    (idu_ready),
        .pc_upd_valid (pc_upd_valid),
        .next_pc      (next_pc),
        .mem_araddr   (mem_araddr),
        .mem_arvalid  (mem_arvalid),
        .mem_arready  (mem_arready),
        .mem_rdata    (mem_rdata),
        .mem_rresp    (mem_rresp),
        .mem_rvalid   (mem_rvalid),
        .mem_rready   (mem_rready),
        .fetch_err    (fetch_err)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".pc"},        pc,          RST_PC);
        chk({tag, ".ins"},       ins,         32'h0);
        chk({tag, ".ifu_valid"}, ifu_valid,   32'h0);
        chk({tag, ".arvalid"},   mem_arvalid, 32'h0);
        chk({tag, ".rready"},    mem_rready,  32'h0);
        chk({tag, ".fetch_err"}, fetch_err,   32'h0);
    endtask

    // One full instruction. Entered at a negedge where the DUT should be
    // presenting the AR request; returns at the negedge of the next request.
    task automatic run_fetch(input int ar_wait, input int r_wait,
                             input logic [31:0] data, input logic [1:0] resp,
                             input int hold_cyc, input int wait_cyc,
                             input logic [31:0] npc);
        // address phase: rvalid noise must be ignored
        for (int i = 0; i <= ar_wait; i++) begin
            chk("req.arvalid", mem_arvalid, 32'h1);
            chk("req.araddr",  mem_araddr,  exp_pc);
            chk("req.ifu_valid", ifu_valid, 32'h0);
            mem_arready = (i == ar_wait);
            mem_rvalid  = 1'($urandom);
            mem_rdata   = $urandom;
            mem_rresp   = 2'($urandom);
            @(negedge clk);
        end
        mem_arready = 1'b0;
        // data phase: commit-stage noise (next_pc 0x1234) must be ignored
        for (int j = 0; j <= r_wait; j++) begin
            chk("resp.rready",  mem_rready,  32'h1);
            chk("resp.arvalid", mem_arvalid, 32'h0);
            chk("resp.ifu_valid", ifu_valid, 32'h0);
            mem_rvalid   = (j == r_wait);
            mem_rdata    = (j == r_wait) ? data : $urandom;
            mem_rresp    = (j == r_wait) ? resp : 2'($urandom);
            pc_upd_valid = 1'($urandom);
            next_pc      = 32'h1234;
            @(negedge clk);
        end
        mem_rvalid = 1'b0;
        exp_ins = (resp == 2'b00) ? data : NOP;
        if (resp != 2'b00) exp_err = 1'b1;
        // hold phase: word and pc frozen until decode takes them
        for (int k = 0; k <= hold_cyc; k++) begin
            chk("hold.ifu_valid", ifu_valid,   32'h1);
            chk("hold.ins",       ins,         exp_ins);
            chk("hold.pc",        pc,          exp_pc);
            chk("hold.arvalid",   mem_arvalid, 32'h0);
            chk("hold.fetch_err", fetch_err,   32'(exp_err));
            idu_ready    = (k == hold_cyc);
            pc_upd_valid = 1'($urandom);
            next_pc      = 32'h1234;
            mem_rvalid   = 1'($urandom);
            @(negedge clk);
        end
        mem_rvalid = 1'b0;
        // wait phase: idle until commit supplies the next PC
        for (int w = 0; w <= wait_cyc; w++) begin
            chk("wait.ifu_valid", ifu_valid,   32'h0);
            chk("wait.arvalid",   mem_arvalid, 32'h0);
            chk("wait.rready",    mem_rready,  32'h0);
            chk("wait.pc",        pc,          exp_pc);
            idu_ready    = 1'($urandom);
            pc_upd_valid = (w == wait_cyc);
            next_pc      = (w == wait_cyc) ? npc : $urandom;
            @(negedge clk);
        end
        pc_upd_valid = 1'b0;
        idu_ready    = 1'b0;
        exp_pc = {npc[31:2], 2'b00};
        if (npc[1:0] != 2'b00) exp_err = 1'b1;
        chk("next.fetch_err", fetch_err, 32'(exp_err));
    endtask

    logic [31:0] npc;
    logic [1:0]  rr;

    initial begin
        // reset held across two edges; outputs checked while still in reset
        repeat (2) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;
        @(negedge clk);
        chk("first.arvalid", mem_arvalid, 32'h1);

        // zero-wait memory
        run_fetch(0, 0, 32'h0010_0093, 2'b00, 0, 0, 32'h8000_0004);
        // AR stalled 3 cycles, R delayed 2 cycles
        run_fetch(3, 2, $urandom, 2'b00, 0, 0, 32'h8000_0008);
        // decode stalls 5 cycles, then redirect to 0x8000_0010
        run_fetch(0, 0, $urandom, 2'b00, 5, 1, 32'h8000_0010);
        chk("redirect.araddr", mem_araddr, 32'h8000_0010);
        // error response -> NOP and sticky error
        run_fetch(0, 0, $urandom, 2'b10, 0, 0, 32'h8000_0014);
        run_fetch(1, 1, $urandom, 2'b00, 1, 2, 32'h8000_0018);
        chk("sticky.fetch_err", fetch_err, 32'h1);
        // misaligned next_pc is aligned and flagged
        run_fetch(0, 1, $urandom, 2'b00, 0, 0, 32'h8000_0006);
        chk("misalign.araddr", mem_araddr, 32'h8000_0004);

        // reset in the middle of the data phase abandons the fetch
        mem_arready = 1'b1;
        @(negedge clk);
        mem_arready = 1'b0;
        chk("midrst.rready", mem_rready, 32'h1);
        rst        = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
        mem_rresp  = 2'b11;
        @(negedge clk);
        mem_rvalid = 1'b0;
        chk_reset_vals("midrst");
        rst = 1'b0;
        exp_pc  = RST_PC;
        exp_err = 1'b0;
        @(negedge clk);
        run_fetch(0, 0, 32'h0000_0513, 2'b00, 0, 0, 32'h8000_0004);

        // randomized instruction stream
        for (int n = 0; n < 40; n++) begin
            rr  = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            npc = ($urandom_range(0, 3) == 0) ? $urandom : exp_pc + 32'd4;
            if ($urandom_range(0, 4) != 0) npc[1:0] = 2'b00;
            run_fetch($urandom_range(0, 3), $urandom_range(0, 3), $urandom, rr,
                      $urandom_range(0, 3), $urandom_range(0, 3), npc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
